// File: rtl/lc3_pkg.sv
// Shared LC-3 execute-stage definitions: opcodes, control-field encodings
// and the sign-extension helper used by the operand and offset paths.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    OFF_11   = 2'b00,
    OFF_9    = 2'b01,
    OFF_6    = 2'b10,
    OFF_ZERO = 2'b11
  } offset_sel_e;

  // e_control = {alu_op[5:4], offset_sel[3:2], base_sel[1], op2_sel[0]}
  localparam int unsigned EC_ALU_MSB = 5;
  localparam int unsigned EC_ALU_LSB = 4;
  localparam int unsigned EC_OFF_MSB = 3;
  localparam int unsigned EC_OFF_LSB = 2;
  localparam int unsigned EC_BASE    = 1;
  localparam int unsigned EC_OP2     = 0;

  function automatic logic [15:0] sext16(input logic [15:0] value, input logic [3:0] msb);
    logic [15:0] res;
    res = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      res[i] = (i > int'(msb)) ? value[msb] : value[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute bus plus the execute stage's results toward writeback
// and memory access; slave is the execute stage, master drives it.
interface execute_if;
  logic        enable_execute;
  logic [5:0]  e_control;
  logic [1:0]  w_control_in;
  logic        mem_control_in;
  logic [15:0] ir;
  logic [15:0] npc_in;
  logic [15:0] vsr1;
  logic [15:0] vsr2;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [15:0] mem_bypass_val;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [15:0] m_data;
  logic [2:0]  dr;
  logic [2:0]  nzp;
  logic [15:0] ir_exec;
  logic [1:0]  w_control_out;
  logic        mem_control_out;

  modport slave (
    input  enable_execute, e_control, w_control_in, mem_control_in, ir, npc_in,
           vsr1, vsr2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
           mem_bypass_val,
    output sr1, sr2, aluout, pcout, m_data, dr, nzp, ir_exec, w_control_out,
           mem_control_out
  );

  modport master (
    output enable_execute, e_control, w_control_in, mem_control_in, ir, npc_in,
           vsr1, vsr2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
           mem_bypass_val,
    input  sr1, sr2, aluout, pcout, m_data, dr, nzp, ir_exec, w_control_out,
           mem_control_out
  );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage; PASS forwards the address-adder
// result so LEA can reuse the adder instead of a second one here.
module exec_alu
  import lc3_pkg::*;
(
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  input  alu_op_e     alu_op,
  input  logic [15:0] addr,
  output logic [15:0] result
);

  // operation select
  always_comb begin
    result = 16'h0000;
    case (alu_op)
      ALU_ADD:  result = op1 + op2;
      ALU_AND:  result = op1 & op2;
      ALU_NOT:  result = ~op1;
      ALU_PASS: result = addr;
      default:  result = 16'h0000;
    endcase
  end

endmodule

// File: rtl/execute.sv
// LC-3 execute stage: forwarding muxes, ALU, address adder and the pipeline
// registers feeding writeback and memory access; advances on enable_execute.
module execute
  import lc3_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  execute_if.slave bus
);

  logic [3:0]  opcode;
  logic [15:0] op1, op2_src, op2, base, offset, addr, alu_result;
  logic [2:0]  nzp_next;
  alu_op_e     alu_op;
  offset_sel_e offset_sel;

  logic [15:0] aluout_d, aluout_q, pcout_d, pcout_q, m_data_d, m_data_q;
  logic [15:0] ir_exec_d, ir_exec_q;
  logic [2:0]  dr_d, dr_q, nzp_d, nzp_q;
  logic [1:0]  w_control_d, w_control_q;
  logic        mem_control_d, mem_control_q;

  assign opcode     = bus.ir[15:12];
  assign alu_op     = alu_op_e'(bus.e_control[EC_ALU_MSB:EC_ALU_LSB]);
  assign offset_sel = offset_sel_e'(bus.e_control[EC_OFF_MSB:EC_OFF_LSB]);

  // source-register numbers; stores read the data register through sr2
  always_comb begin
    bus.sr1 = bus.ir[8:6];
    if (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI) begin
      bus.sr2 = bus.ir[11:9];
    end else begin
      bus.sr2 = bus.ir[2:0];
    end
  end

  // operand forwarding: the ALU result is the youngest producer, so it wins
  always_comb begin
    op1     = bus.vsr1;
    op2_src = bus.vsr2;
    if (bus.bypass_alu_1) begin
      op1 = aluout_q;
    end else if (bus.bypass_mem_1) begin
      op1 = bus.mem_bypass_val;
    end else begin
      op1 = bus.vsr1;
    end
    if (bus.bypass_alu_2) begin
      op2_src = aluout_q;
    end else if (bus.bypass_mem_2) begin
      op2_src = bus.mem_bypass_val;
    end else begin
      op2_src = bus.vsr2;
    end
    if (bus.e_control[EC_OP2]) begin
      op2 = op2_src;
    end else begin
      op2 = sext16(bus.ir, 4'd4);
    end
  end

  // address adder: base plus selected PC/base offset, wrapping mod 2^16
  always_comb begin
    offset = 16'h0000;
    if (bus.e_control[EC_BASE]) begin
      base = bus.npc_in;
    end else begin
      base = op1;
    end
    case (offset_sel)
      OFF_11:   offset = sext16(bus.ir, 4'd10);
      OFF_9:    offset = sext16(bus.ir, 4'd8);
      OFF_6:    offset = sext16(bus.ir, 4'd5);
      OFF_ZERO: offset = 16'h0000;
      default:  offset = 16'h0000;
    endcase
    addr = base + offset;
  end

  // branch mask: BR carries its own nzp bits, JMP/RET is unconditional
  always_comb begin
    nzp_next = 3'b000;
    case (opcode)
      OP_BR:   nzp_next = bus.ir[11:9];
      OP_JMP:  nzp_next = 3'b111;
      default: nzp_next = 3'b000;
    endcase
  end

  exec_alu u_alu (
    .op1    (op1),
    .op2    (op2),
    .alu_op (alu_op),
    .addr   (addr),
    .result (alu_result)
  );

  // next-state: capture on enable, otherwise hold
  always_comb begin
    aluout_d      = aluout_q;
    pcout_d       = pcout_q;
    m_data_d      = m_data_q;
    dr_d          = dr_q;
    nzp_d         = nzp_q;
    ir_exec_d     = ir_exec_q;
    w_control_d   = w_control_q;
    mem_control_d = mem_control_q;
    if (bus.enable_execute) begin
      aluout_d      = alu_result;
      pcout_d       = addr;
      m_data_d      = op2_src;
      dr_d          = bus.ir[11:9];
      nzp_d         = nzp_next;
      ir_exec_d     = bus.ir;
      w_control_d   = bus.w_control_in;
      mem_control_d = bus.mem_control_in;
    end else begin
      aluout_d      = aluout_q;
    end
  end

  // pipeline registers; reset overrides enable
  always_ff @(posedge clk) begin
    if (rst) begin
      aluout_q      <= 16'h0000;
      pcout_q       <= 16'h0000;
      m_data_q      <= 16'h0000;
      dr_q          <= 3'b000;
      nzp_q         <= 3'b000;
      ir_exec_q     <= 16'h0000;
      w_control_q   <= 2'b00;
      mem_control_q <= 1'b0;
    end else begin
      aluout_q      <= aluout_d;
      pcout_q       <= pcout_d;
      m_data_q      <= m_data_d;
      dr_q          <= dr_d;
      nzp_q         <= nzp_d;
      ir_exec_q     <= ir_exec_d;
      w_control_q   <= w_control_d;
      mem_control_q <= mem_control_d;
    end
  end

  assign bus.aluout          = aluout_q;
  assign bus.pcout           = pcout_q;
  assign bus.m_data          = m_data_q;
  assign bus.dr              = dr_q;
  assign bus.nzp             = nzp_q;
  assign bus.ir_exec         = ir_exec_q;
  assign bus.w_control_out   = w_control_q;
  assign bus.mem_control_out = mem_control_q;

endmodule

// File: tb/tb_execute.sv
// Bench for the LC-3 execute stage: an instruction-level reference model
// checked every cycle, plus hand-computed expectations for directed vectors.
module tb_execute;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_if bus ();

  execute u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  logic [15:0] m_alu, m_pc, m_mdata, m_irx;
  logic [2:0]  m_dr, m_nzp;
  logic [1:0]  m_w;
  logic        m_mem;

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    int x;
    x = int'(v) & ((1 << bits) - 1);
    if (x >= (1 << (bits - 1))) x = x - (1 << bits);
    return 16'(x);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: what one LC-3 execute step must produce
  always @(posedge clk) begin : model
    logic [15:0] a, bsrc, b, base, off, addr, res;
    logic [3:0]  opc;
    if (rst) begin
      m_alu <= 16'h0000; m_pc <= 16'h0000; m_mdata <= 16'h0000; m_irx <= 16'h0000;
      m_dr <= 3'b000; m_nzp <= 3'b000; m_w <= 2'b00; m_mem <= 1'b0;
    end else if (bus.enable_execute) begin
      a    = bus.bypass_alu_1 ? m_alu : (bus.bypass_mem_1 ? bus.mem_bypass_val : bus.vsr1);
      bsrc = bus.bypass_alu_2 ? m_alu : (bus.bypass_mem_2 ? bus.mem_bypass_val : bus.vsr2);
      b    = bus.e_control[0] ? bsrc : sx(bus.ir, 5);
      base = bus.e_control[1] ? bus.npc_in : a;
      case (bus.e_control[3:2])
        2'd0:    off = sx(bus.ir, 11);
        2'd1:    off = sx(bus.ir, 9);
        2'd2:    off = sx(bus.ir, 6);
        default: off = 16'h0000;
      endcase
      addr = 16'((int'(base) + int'(off)) % 65536);
      case (bus.e_control[5:4])
        2'd0:    res = 16'((int'(a) + int'(b)) % 65536);
        2'd1:    res = a & b;
        2'd2:    res = ~a;
        default: res = addr;
      endcase
      opc = bus.ir[15:12];
      m_alu   <= res;
      m_pc    <= addr;
      m_mdata <= bsrc;
      m_irx   <= bus.ir;
      m_dr    <= bus.ir[11:9];
      m_nzp   <= (opc == 4'd0) ? bus.ir[11:9] : ((opc == 4'd12) ? 3'b111 : 3'b000);
      m_w     <= bus.w_control_in;
      m_mem   <= bus.mem_control_in;
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    logic [3:0] opc;
    logic [2:0] e_sr2;
    if (checking) begin
      opc   = bus.ir[15:12];
      e_sr2 = (opc == 4'd3 || opc == 4'd7 || opc == 4'd11) ? bus.ir[11:9] : bus.ir[2:0];
      check("aluout", bus.aluout, m_alu);
      check("pcout", bus.pcout, m_pc);
      check("m_data", bus.m_data, m_mdata);
      check("ir_exec", bus.ir_exec, m_irx);
      check("dr", 16'(bus.dr), 16'(m_dr));
      check("nzp", 16'(bus.nzp), 16'(m_nzp));
      check("w_control_out", 16'(bus.w_control_out), 16'(m_w));
      check("mem_control_out", 16'(bus.mem_control_out), 16'(m_mem));
      check("sr1", 16'(bus.sr1), 16'(bus.ir[8:6]));
      check("sr2", 16'(bus.sr2), 16'(e_sr2));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_bypass();
    bus.bypass_alu_1 = 1'b0; bus.bypass_alu_2 = 1'b0;
    bus.bypass_mem_1 = 1'b0; bus.bypass_mem_2 = 1'b0;
  endtask

  task automatic drive(input logic [15:0] ir, input logic [5:0] ec, input logic [15:0] v1,
                       input logic [15:0] v2, input logic [15:0] npc);
    bus.ir = ir; bus.e_control = ec; bus.vsr1 = v1; bus.vsr2 = v2; bus.npc_in = npc;
  endtask

  localparam logic [15:0] HOLD_IR [5] = '{16'h3A47, 16'h1283, 16'hB1C5, 16'h0000, 16'hFFFF};

  initial begin
    rst = 1'b1;
    bus.enable_execute = 1'b0;
    drive(16'hDEAD, 6'h3F, 16'hAAAA, 16'h5555, 16'h1234);
    bus.bypass_alu_1 = 1'b1; bus.bypass_alu_2 = 1'b1;
    bus.bypass_mem_1 = 1'b1; bus.bypass_mem_2 = 1'b1;
    bus.mem_bypass_val = 16'hCAFE; bus.w_control_in = 2'b11; bus.mem_control_in = 1'b1;
    step(); step();
    checking = 1'b1;
    check("rst_aluout", bus.aluout, 16'h0000);
    check("rst_ir_exec", bus.ir_exec, 16'h0000);
    bus.enable_execute = 1'b1;
    step();
    check("rst_en_pcout", bus.pcout, 16'h0000);
    check("rst_en_mem_ctl", 16'(bus.mem_control_out), 16'h0000);

    // ADD R1,R1,#2
    rst = 1'b0; clear_bypass();
    bus.w_control_in = 2'b00; bus.mem_control_in = 1'b0;
    drive(16'h1262, 6'b000000, 16'h0005, 16'h0000, 16'h3001);
    step();
    check("add_aluout", bus.aluout, 16'h0007);
    check("add_dr", 16'(bus.dr), 16'h0001);
    check("add_sr1", 16'(bus.sr1), 16'h0001);
    check("add_nzp", 16'(bus.nzp), 16'h0000);
    check("model_add", m_alu, 16'h0007);

    // forwarding priority on operand 1
    drive(16'h1260, 6'b000000, 16'h1000, 16'h0000, 16'h3002);
    step();
    bus.bypass_alu_1 = 1'b1; bus.bypass_mem_1 = 1'b1;
    bus.mem_bypass_val = 16'h2000; bus.vsr1 = 16'h0001;
    step();
    check("fwd_both", bus.aluout, 16'h1000);
    bus.bypass_alu_1 = 1'b0;
    step();
    check("fwd_mem", bus.aluout, 16'h2000);
    check("model_fwd_mem", m_alu, 16'h2000);

    // AND with memory forward on operand 2
    clear_bypass();
    bus.bypass_mem_2 = 1'b1; bus.mem_bypass_val = 16'h3C3C;
    drive(16'h5042, 6'b010001, 16'hF0F0, 16'hFFFF, 16'h3003);
    step();
    check("and_aluout", bus.aluout, 16'h3030);
    check("and_m_data", bus.m_data, 16'h3C3C);

    // NOT, then ADD with carry out dropped
    clear_bypass();
    drive(16'h907F, 6'b100000, 16'h00FF, 16'h0000, 16'h3004);
    step();
    check("not_aluout", bus.aluout, 16'hFF00);
    drive(16'h1262, 6'b000000, 16'hFFFF, 16'h0000, 16'h3005);
    step();
    check("add_wrap", bus.aluout, 16'h0001);

    // branch with address wrap in both directions
    drive(16'h0FFF, 6'b000110, 16'h0000, 16'h0000, 16'h0000);
    step();
    check("br_back_pcout", bus.pcout, 16'hFFFF);
    check("br_nzp", 16'(bus.nzp), 16'h0007);
    drive(16'h0E01, 6'b000110, 16'h0000, 16'h0000, 16'hFFFF);
    step();
    check("br_fwd_pcout", bus.pcout, 16'h0000);
    check("model_br_wrap", m_pc, 16'h0000);

    // JMP R7 and LEA R2,#-1
    drive(16'hC1C0, 6'b001100, 16'h4000, 16'h0000, 16'h3006);
    step();
    check("jmp_pcout", bus.pcout, 16'h4000);
    check("jmp_nzp", 16'(bus.nzp), 16'h0007);
    drive(16'hE5FF, 6'b110110, 16'h0000, 16'h0000, 16'h3000);
    step();
    check("lea_aluout", bus.aluout, 16'h2FFF);
    check("lea_nzp", 16'(bus.nzp), 16'h0000);

    // STR R2,R1,#2
    bus.mem_control_in = 1'b1; bus.w_control_in = 2'b01;
    drive(16'h7442, 6'b001001, 16'h3000, 16'hBEEF, 16'h3008);
    step();
    check("str_pcout", bus.pcout, 16'h3002);
    check("str_m_data", bus.m_data, 16'hBEEF);
    check("str_sr2", 16'(bus.sr2), 16'h0002);
    check("str_mem_ctl", 16'(bus.mem_control_out), 16'h0001);
    check("str_w_ctl", 16'(bus.w_control_out), 16'h0001);

    // hold: every input moves, registered outputs must not
    bus.enable_execute = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(HOLD_IR[i], 6'(i * 13), 16'(i * 16'h1111), 16'(~(i * 16'h0707)), 16'(i * 16'h2222));
      bus.bypass_alu_1 = i[0]; bus.bypass_mem_2 = i[1];
      bus.mem_bypass_val = 16'(i * 16'h0F0F); bus.mem_control_in = i[0];
      bus.w_control_in = 2'(i);
      step();
      check("hold_pcout", bus.pcout, 16'h3002);
      check("hold_m_data", bus.m_data, 16'hBEEF);
    end
    check("hold_sr1_last", 16'(bus.sr1), 16'h0007);

    // reset while an instruction is being captured
    clear_bypass();
    bus.enable_execute = 1'b1; rst = 1'b1;
    drive(16'h1262, 6'b000000, 16'h0005, 16'h0000, 16'h3001);
    step();
    check("midrst_aluout", bus.aluout, 16'h0000);
    check("midrst_m_data", bus.m_data, 16'h0000);
    rst = 1'b0; bus.enable_execute = 1'b0;
    step();
    check("post_rst_hold", bus.pcout, 16'h0000);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
